// File: rtl/logic_analyzer.sv
// -----------------------------------------------------------------------------
// logic_analyzer
// 32-channel, 32-deep sample-capture logic analyzer for the DLX debug path.
//
// The host arms the block while in init mode. Dropping in_init starts the
// capture: SIGNALS is stored once per clock into the sample RAM until the RAM
// fills or the host returns to init mode. Samples are read back through
// AI/RAM_OUT with one clock of latency. STATUS_OUT reports progress as
// {full, running, armed, wptr[4:0]}.
//
// Handshake: there is no valid/ready pair. step_en is a level request that is
// sampled on the rising edge and only acts while in_init=1 in IDLE or DONE.
// AI is accepted on every rising edge and its word appears on RAM_OUT after
// that edge.
//
// The sample RAM has no reset, so captured data survives a stop_n pulse.
// -----------------------------------------------------------------------------
module logic_analyzer #(
   parameter int WIDTH = 32,
   parameter int AW    = 5
) (
   input  logic             CLK,
   input  logic             stop_n,
   input  logic [WIDTH-1:0] SIGNALS,
   input  logic             step_en,
   input  logic             in_init,
   input  logic [AW-1:0]    AI,
   output logic [WIDTH-1:0] RAM_OUT,
   output logic [7:0]       STATUS_OUT
);

   localparam int            DEPTH     = 1 << AW;
   localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

   // Capture sequencer states. The state is visible to the host through the
   // armed/running/full bits of STATUS_OUT.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [AW-1:0]    wptr_q,  wptr_d;
   logic             full_q,  full_d;
   logic             wr_en;
   logic [WIDTH-1:0] ram_out_q;
   logic [WIDTH-1:0] mem_q [DEPTH];

   // Control registers: state, write pointer and full flag; stop_n aborts.
   always_ff @(posedge CLK or negedge stop_n) begin
      if (!stop_n) begin
         state_q <= ST_IDLE;
         wptr_q  <= '0;
         full_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         full_q  <= full_d;
      end
   end

   // Next-state logic: arming, capture stepping and the stop-on-full rule.
   always_comb begin
      state_d = state_q;
      wptr_d  = wptr_q;
      full_d  = full_q;
      wr_en   = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            // Arming restarts the capture at address 0 and clears full.
            if (in_init && step_en) begin
               state_d = ST_ARMED;
               wptr_d  = '0;
               full_d  = 1'b0;
            end
         end
         ST_ARMED: begin
            // The edge that leaves ARMED does not store a sample.
            if (!in_init) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (in_init) begin
               // Host took control back: stop, keep pointer for inspection.
               state_d = ST_IDLE;
            end else begin
               wr_en = 1'b1;
               if (wptr_q == LAST_ADDR) begin
                  // Last slot written: pointer parks at the top, no wrap.
                  full_d  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  wptr_d = wptr_q + AW'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Sample RAM write port; intentionally not reset so captures survive stop_n.
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         mem_q[wptr_q] <= SIGNALS;
      end
   end

   // Registered read port; reads the pre-write word on an address collision.
   always_ff @(posedge CLK or negedge stop_n) begin
      if (!stop_n) begin
         ram_out_q <= '0;
      end else begin
         ram_out_q <= mem_q[AI];
      end
   end

   assign RAM_OUT = ram_out_q;

   // Status word is decoded from registered state, so it shows post-edge values.
   always_comb begin
      STATUS_OUT    = 8'h00;
      STATUS_OUT[7] = full_q;
      STATUS_OUT[6] = (state_q == ST_RUN);
      STATUS_OUT[5] = (state_q == ST_ARMED);
      STATUS_OUT[4:0] = 5'(wptr_q);
   end

endmodule

// File: tb/tb_logic_analyzer.sv
// -----------------------------------------------------------------------------
// tb_logic_analyzer
// Directed scenarios followed by randomized host/run traffic, checked against
// a behavioural model of the capture rules (sample array plus progress flags).
// -----------------------------------------------------------------------------
module tb_logic_analyzer;

   localparam logic [31:0] FILL_BASE = 32'hA000_0000;
   localparam logic [31:0] INIT_BASE = 32'h5500_0000;

   logic        CLK = 1'b0;
   logic        stop_n;
   logic [31:0] SIGNALS;
   logic        step_en;
   logic        in_init;
   logic [4:0]  AI;
   logic [31:0] RAM_OUT;
   logic [7:0]  STATUS_OUT;

   int total = 0;
   int bad   = 0;

   // Behavioural model: what the host should see.
   logic [31:0] m_mem [32];
   bit          m_vld [32];
   bit          m_armed   = 0;
   bit          m_running = 0;
   bit          m_full    = 0;
   int          m_count   = 0;

   // Expected RAM_OUT per edge: {known, data}.
   logic [32:0] exp_q[$];

   logic_analyzer #(.WIDTH(32), .AW(5)) dut (
      .CLK        (CLK),
      .stop_n     (stop_n),
      .SIGNALS    (SIGNALS),
      .step_en    (step_en),
      .in_init    (in_init),
      .AI         (AI),
      .RAM_OUT    (RAM_OUT),
      .STATUS_OUT (STATUS_OUT)
   );

   // ---------------- clock / watchdog ----------------
   always #5 CLK = ~CLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] model_status();
      return {m_full, m_running, m_armed, 5'(m_count)};
   endfunction

   // Apply one edge of the capture rules to the model.
   task automatic model_edge(input logic init, input logic step, input logic [31:0] sig);
      if (m_running) begin
         if (init) begin
            m_running = 0;
         end else begin
            m_mem[m_count] = sig;
            m_vld[m_count] = 1;
            if (m_count == 31) begin
               m_full    = 1;
               m_running = 0;
            end else begin
               m_count++;
            end
         end
      end else if (m_armed) begin
         if (!init) begin
            m_armed   = 0;
            m_running = 1;
         end
      end else if (init && step) begin
         m_armed = 1;
         m_count = 0;
         m_full  = 0;
      end
   endtask

   // ---------------- driver tasks ----------------
   // Called at posedge+1; drives inputs, advances one edge, checks at posedge+1.
   task automatic tick(input logic init, input logic step, input logic [31:0] sig,
                       input logic [4:0] ai);
      logic [32:0] e;
      in_init = init;
      step_en = step;
      SIGNALS = sig;
      AI      = ai;
      exp_q.push_back({m_vld[ai], m_mem[ai]});
      model_edge(init, step, sig);
      @(posedge CLK);
      #1;
      e = exp_q.pop_front();
      if (e[32]) check("ram_out", RAM_OUT, e[31:0]);
      check("status", 32'(STATUS_OUT), 32'(model_status()));
   endtask

   // Asynchronous stop in the middle of a cycle, held across one edge.
   task automatic do_stop();
      #2;
      stop_n = 1'b0;
      #1;
      m_armed = 0; m_running = 0; m_full = 0; m_count = 0;
      check("stop_status_async", 32'(STATUS_OUT), 32'h0);
      check("stop_ram_async", RAM_OUT, 32'h0);
      @(posedge CLK);
      #1;
      check("stop_status_held", 32'(STATUS_OUT), 32'h0);
      stop_n = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      stop_n  = 1'b0;
      in_init = 1'b1;
      step_en = 1'b0;
      SIGNALS = '0;
      AI      = '0;
      for (int i = 0; i < 32; i++) begin
         m_mem[i] = '0;
         m_vld[i] = 0;
      end

      // Reset state.
      #1;
      check("rst_status", 32'(STATUS_OUT), 32'h0);
      check("rst_ram", RAM_OUT, 32'h0);
      repeat (2) @(posedge CLK);
      #1;
      check("rst_status_edge", 32'(STATUS_OUT), 32'h0);
      stop_n = 1'b1;
      repeat (3) tick(1'b1, 1'b0, 32'h0, 5'd0);

      // Fill: arm, then run well past 32 edges with a counting sample value.
      tick(1'b1, 1'b1, 32'h0, 5'd0);
      check("fill_arm", 32'(STATUS_OUT), 32'h20);
      for (int k = 0; k < 36; k++) tick(1'b0, 1'b0, FILL_BASE + 32'(k), 5'(k));
      check("fill_status", 32'(STATUS_OUT), 32'h9F);
      for (int k = 0; k < 32; k++) begin
         tick(1'b1, 1'b0, 32'hDEAD_BEEF, 5'(k));
         check("fill_word", RAM_OUT, FILL_BASE + 32'(k) + 32'd1);
      end

      // Arm and capture four samples, then stop mid-run.
      tick(1'b1, 1'b1, 32'h1, 5'd0);
      check("cap_arm", 32'(STATUS_OUT), 32'h20);
      tick(1'b0, 1'b0, 32'h1, 5'd0);
      check("cap_run", 32'(STATUS_OUT), 32'h40);
      repeat (4) tick(1'b0, 1'b0, 32'h1, 5'd9);
      check("cap_four", 32'(STATUS_OUT), 32'h44);
      do_stop();
      for (int k = 0; k < 5; k++) begin
         tick(1'b1, 1'b0, 32'h0, 5'(k));
         check("stop_read", RAM_OUT, (k < 4) ? 32'h1 : FILL_BASE + 32'd5);
      end
      repeat (2) tick(1'b1, 1'b0, 32'h0, 5'd0);
      check("stop_idle", 32'(STATUS_OUT), 32'h0);

      // Read latency: AI moves 3 -> 7 between edges.
      tick(1'b1, 1'b0, 32'h0, 5'd3);
      AI = 5'd7;
      #2;
      check("lat_hold", RAM_OUT, 32'h1);
      tick(1'b1, 1'b0, 32'h0, 5'd7);
      check("lat_new", RAM_OUT, FILL_BASE + 32'd8);

      // Init during run, reading the address being written each edge.
      tick(1'b1, 1'b1, 32'h0, 5'd0);
      tick(1'b0, 1'b0, 32'h0, 5'd0);
      for (int k = 0; k < 10; k++) begin
         tick(1'b0, 1'b0, INIT_BASE + 32'(k), 5'(k));
         check("collide_old", RAM_OUT, (k < 4) ? 32'h1 : FILL_BASE + 32'(k) + 32'd1);
      end
      tick(1'b1, 1'b0, 32'hFFFF_FFFF, 5'd10);
      check("init_stop", 32'(STATUS_OUT), 32'h0A);
      tick(1'b1, 1'b0, 32'hFFFF_FFFF, 5'd10);
      check("init_nowrite", RAM_OUT, FILL_BASE + 32'd11);
      tick(1'b1, 1'b1, 32'h0, 5'd9);
      check("init_rearm", 32'(STATUS_OUT), 32'h20);
      check("init_kept", RAM_OUT, INIT_BASE + 32'd9);

      // Randomized host/run traffic.
      for (int seg = 0; seg < 40; seg++) begin
         logic init;
         int   len;
         init = ($urandom_range(0, 2) == 0);
         len  = (init != 0) ? $urandom_range(1, 6) : $urandom_range(1, 40);
         if (seg == 20) do_stop();
         for (int c = 0; c < len; c++) begin
            logic [4:0] ai;
            ai = ($urandom_range(0, 3) == 0) ? 5'(m_count) : 5'($urandom_range(0, 31));
            tick(init, ($urandom_range(0, 3) == 0), $urandom, ai);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/logic_analyzer.md
Name: logic_analyzer

Overview:
- 32-channel, 32-deep sample-capture logic analyzer for the extended DLX debug path.
- Host arms it during init mode. Leaving init mode starts capture: `SIGNALS` is written into an internal RAM once per clock until the RAM fills or init mode returns.
- Host reads samples back through `AI`/`RAM_OUT`. `STATUS_OUT` gives progress.

Parameters:
- `WIDTH`, 32, sample width (`SIGNALS` / `RAM_OUT`).
- `AW`, 5, address width; depth = 2^`AW` = 32 samples.

Ports:
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `stop_n`  in  1  reset: asynchronous, active-low. Aborts capture and clears control state.
- `SIGNALS`  in  `WIDTH`  probed signals to sample.
- `step_en`  in  1  arm request; only honoured while `in_init`=1.
- `in_init`  in  1  1 = host/init mode (no capture, arming allowed); 0 = run mode.
- `AI`  in  `AW`  host read address into the sample RAM.
- `RAM_OUT`  out  `WIDTH`  registered read data, RAM[`AI`].
- `STATUS_OUT`  out  8  {`full`, `running`, `armed`, `wptr[4:0]`} (bit 7 down to bit 0).

Behaviour:
- Reset: `stop_n`=0 immediately forces:
  - state=IDLE, `wptr`=0, `full`=0
  - `RAM_OUT`=0, `STATUS_OUT`=0x00
  - RAM array is NOT cleared, so captured samples survive a stop/reset and stay readable.
- States: IDLE, ARMED, RUN, DONE. `armed`=1 only in ARMED; `running`=1 only in RUN.
- IDLE→ARMED: edge with `in_init`=1 and `step_en`=1. This edge also clears `wptr` to 0 and `full` to 0.
- ARMED→RUN: first edge with `in_init`=0. No sample is written on this edge.
- ARMED stays ARMED while `in_init`=1. `step_en` re-asserted in ARMED has no further effect.
- RUN, each edge:
  - RAM[`wptr`] <= `SIGNALS`.
  - If `wptr`=31: set `full`=1, state → DONE, `wptr` holds at 31 (no wrap).
  - Otherwise `wptr` <= `wptr`+1.
- RUN with `in_init`=1 on an edge: no write; state → IDLE, `wptr` and `full` retained.
- DONE: no writes. With `in_init`=1 and `step_en`=1 → ARMED, clearing `wptr`/`full` as above.
- Readback: `RAM_OUT` <= RAM[`AI`] every edge in every state, so latency is 1 clock.
  - Same-edge read and write at one address returns the old contents (read-before-write).
- `STATUS_OUT` is combinational from the registered state, `full` and `wptr`; it reflects post-edge values.
- `step_en` is sampled only on the clock edge. A pulse that spans no rising edge is ignored.
- `stop_n` deassertion is synchronous-safe: the first edge after release behaves as IDLE.
- Only synchronous single-port-write / single-read RAM semantics are required. Inferring a 32x32 register array is acceptable.

Test Plan:
- Reset:
  - Stimulus: `stop_n`=0 at time 0, `in_init`=1.
  - Required: `STATUS_OUT`=0x00, `RAM_OUT`=0; after release with no `step_en`, state remains IDLE.
- Arm and capture:
  - Stimulus: `SIGNALS`=0x00000001, `in_init`=1; `step_en`=1 for one edge (`STATUS_OUT`=0x20); then `in_init`=0, `step_en`=0.
  - Required: next edge `STATUS_OUT`=0x40; after 4 further edges `STATUS_OUT`=0x44.
- Stop mid-run:
  - Stimulus: continuing from arm and capture, `stop_n`=0 asynchronously after 4 samples, then release and `in_init`=1.
  - Required: `STATUS_OUT`=0x00 immediately; reading `AI`=0..3 gives 0x00000001 one clock later; `AI`=4 returns its pre-existing contents.
- Fill:
  - Stimulus: arm, run 32+ edges with `SIGNALS`=counter value.
  - Required: `STATUS_OUT`=0x9F (full, DONE, `wptr`=31); RAM[k] holds the k-th sample; extra edges write nothing.
- Init during run:
  - Stimulus: arm, run 10 edges, set `in_init`=1.
  - Required: state IDLE, `STATUS_OUT`=0x0A, no more writes.
  - Then `step_en`=1 → `STATUS_OUT`=0x20.
- Read latency / collision:
  - Stimulus: `AI` changed from 3 to 7 between edges; separately, `AI`=`wptr` during RUN.
  - Required: `RAM_OUT` updates exactly one edge later; in the collision case `RAM_OUT` shows the old word.
